// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter sharing one UART transmitter byte
// channel between NUM_REQ byte sources. A grant is held for one packet and
// released on the BURST_MAX-th byte, on a stall of HOLD_CYCLES consecutive
// cycles, or (when UART_ARB_EOP_EN is defined) on an EOP_BYTE acceptance.
// A single output register feeds the transmitter and drains independently
// of the arbitration state.
module uart_tx_arbiter #(
  parameter int         NUM_REQ     = 2,
  parameter int         BURST_MAX   = 16,
  parameter int         HOLD_CYCLES = 1024,
  parameter logic [7:0] EOP_BYTE    = 8'h0A
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [8*NUM_REQ-1:0]   req_data,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [7:0]             tx_data,
  output logic                   tx_valid,
  input  logic                   tx_ready,
  output logic [NUM_REQ-1:0]     grant,
  output logic                   busy
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int BC_W  = $clog2(BURST_MAX + 1);
  localparam int HC_W  = $clog2(HOLD_CYCLES + 1);

  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REQ - 1);
  localparam logic [BC_W-1:0]  BURST_LIM = BC_W'(BURST_MAX);
  localparam logic [HC_W-1:0]  HOLD_LIM  = HC_W'(HOLD_CYCLES);

`ifdef UART_ARB_EOP_EN
  localparam logic EOP_EN = 1'b1;
`else
  localparam logic EOP_EN = 1'b0;
`endif

  typedef enum logic {IDLE, GRANT} state_t;

  state_t             state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]   last_q, last_d;      // current owner while in GRANT
  logic [BC_W-1:0]    byte_cnt_q, byte_cnt_d;
  logic [HC_W-1:0]    hold_cnt_q, hold_cnt_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic               tx_valid_q, tx_valid_d;

  logic [7:0]         req_byte [NUM_REQ];
  logic [IDX_W-1:0]   cand;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_found;
  logic               out_free;
  logic               accept;
  logic [7:0]         cur_byte;
  logic [BC_W-1:0]    byte_cnt_inc;
  logic [HC_W-1:0]    hold_cnt_inc;

  // Split the flat data bus into one byte per requester.
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_split
      assign req_byte[gi] = req_data[8*gi +: 8];
    end
  endgenerate

  // Round-robin search: first valid requester starting after the last owner.
  always_comb begin
    cand       = last_q;
    pick_idx   = last_q;
    pick_found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = (cand == LAST_IDX) ? '0 : cand + 1'b1;
      if (!pick_found && req_valid[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  assign out_free     = ~tx_valid_q | tx_ready;
  assign cur_byte     = req_byte[last_q];
  assign accept       = (state_q == GRANT) && req_valid[last_q] && out_free;
  assign byte_cnt_inc = byte_cnt_q + 1'b1;
  assign hold_cnt_inc = hold_cnt_q + 1'b1;

  // Next-state, handshake and output-register update.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    last_d     = last_q;
    byte_cnt_d = byte_cnt_q;
    hold_cnt_d = hold_cnt_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    req_ready  = '0;

    // Output register drains on its own; a new byte overrides the drain.
    if (tx_ready) begin
      tx_valid_d = 1'b0;
    end
    if (accept) begin
      tx_data_d  = cur_byte;
      tx_valid_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d    = GRANT;
          grant_d    = NUM_REQ'(1) << pick_idx;
          last_d     = pick_idx;
          byte_cnt_d = '0;
          hold_cnt_d = '0;
        end
      end
      GRANT: begin
        req_ready[last_q] = out_free;
        if (accept) begin
          byte_cnt_d = byte_cnt_inc;
          hold_cnt_d = '0;
          if ((byte_cnt_inc == BURST_LIM) || (EOP_EN && (cur_byte == EOP_BYTE))) begin
            state_d = IDLE;
            grant_d = '0;
          end
        end else if (!req_valid[last_q]) begin
          hold_cnt_d = hold_cnt_inc;
          if (hold_cnt_inc == HOLD_LIM) begin
            state_d = IDLE;
            grant_d = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  // State and datapath registers; requester 0 wins first after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      last_q     <= LAST_IDX;
      byte_cnt_q <= '0;
      hold_cnt_q <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      last_q     <= last_d;
      byte_cnt_q <= byte_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
    end
  end

  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign grant    = grant_q;
  assign busy     = (state_q == GRANT);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed testbench for uart_tx_arbiter (NUM_REQ=2, BURST_MAX=16,
// HOLD_CYCLES=8). Expected values follow UART_ARB_EOP_EN when defined.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] req_data = '0;
  logic [1:0]  req_valid = '0;
  logic [1:0]  req_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [1:0]  grant;
  logic        busy;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic [7:0] txlog[$];
  bit acc0 = 1'b0;
  bit acc1 = 1'b0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .NUM_REQ(2), .BURST_MAX(16), .HOLD_CYCLES(8), .EOP_BYTE(8'h0A)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req_data(req_data), .req_valid(req_valid),
    .req_ready(req_ready), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .grant(grant), .busy(busy)
  );

  // Sample handshakes mid-cycle; they complete at the following rising edge.
  always @(negedge clk) begin
    acc0 = req_valid[0] & req_ready[0];
    acc1 = req_valid[1] & req_ready[1];
    if (tx_valid && tx_ready) txlog.push_back(tx_data);
  end

  // Source model: pop accepted bytes, present queue heads.
  always @(posedge clk) begin
    #1;
    if (acc0 && q0.size() > 0) void'(q0.pop_front());
    if (acc1 && q1.size() > 0) void'(q1.pop_front());
    acc0 = 1'b0;
    acc1 = 1'b0;
    req_valid = {q1.size() != 0, q0.size() != 0};
    req_data  = {(q1.size() != 0) ? q1[0] : 8'h00, (q0.size() != 0) ? q0[0] : 8'h00};
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (!(busy === 1'b0 && tx_valid === 1'b0 && q0.size() == 0 && q1.size() == 0) && n < 400) begin
      tick();
      n++;
    end
    vectors++;
    if (n >= 400) begin
      miscompares++;
      $display("FAIL %s_idle: busy=%b tx_valid=%b q0=%0d q1=%0d, expected idle within 400 cycles",
               tag, busy, tx_valid, q0.size(), q1.size());
    end
  endtask

  task automatic test_reset();
    logic [7:0] exp[$];
    rst_n = 1'b0;
    tx_ready = 1'b1;
    q0.push_back(8'h11);
    q1.push_back(8'h22);
    repeat (3) tick();
    vectors++;
    if (grant !== 2'b00 || busy !== 1'b0 || tx_valid !== 1'b0 || req_ready !== 2'b00 || tx_data !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_state: grant=%b busy=%b tx_valid=%b req_ready=%b tx_data=%h, expected 00 0 0 00 00",
               grant, busy, tx_valid, req_ready, tx_data);
    end
    rst_n = 1'b1;
    txlog.delete();
    tick();
    vectors++;
    if (grant !== 2'b01 || busy !== 1'b1 || req_ready !== 2'b01) begin
      miscompares++;
      $display("FAIL reset_first_grant: grant=%b busy=%b req_ready=%b, expected 01 1 01", grant, busy, req_ready);
    end
    wait_idle("reset");
    exp.push_back(8'h11);
    exp.push_back(8'h22);
    vectors++;
    if (txlog.size() != exp.size()) begin
      miscompares++;
      $display("FAIL reset_len: got %0d bytes, expected %0d", txlog.size(), exp.size());
    end
    for (int i = 0; i < exp.size() && i < txlog.size(); i++) begin
      vectors++;
      if (txlog[i] !== exp[i]) begin
        miscompares++;
        $display("FAIL reset_byte%0d: got %h expected %h", i, txlog[i], exp[i]);
      end
    end
  endtask

  task automatic test_contention();
    logic [7:0] exp[$];
    txlog.delete();
    for (int i = 0; i < 3; i++) begin
      q0.push_back(8'h41); q0.push_back(8'h0A);
      q1.push_back(8'h62); q1.push_back(8'h0A);
    end
`ifdef UART_ARB_EOP_EN
    for (int i = 0; i < 3; i++) begin
      exp.push_back(8'h41); exp.push_back(8'h0A);
      exp.push_back(8'h62); exp.push_back(8'h0A);
    end
`else
    for (int i = 0; i < 3; i++) begin exp.push_back(8'h41); exp.push_back(8'h0A); end
    for (int i = 0; i < 3; i++) begin exp.push_back(8'h62); exp.push_back(8'h0A); end
`endif
    wait_idle("contention");
    vectors++;
    if (txlog.size() != exp.size()) begin
      miscompares++;
      $display("FAIL contention_len: got %0d bytes, expected %0d", txlog.size(), exp.size());
    end
    for (int i = 0; i < exp.size() && i < txlog.size(); i++) begin
      vectors++;
      if (txlog[i] !== exp[i]) begin
        miscompares++;
        $display("FAIL contention_byte%0d: got %h expected %h", i, txlog[i], exp[i]);
      end
    end
  endtask

  task automatic test_single();
    logic [7:0] exp[$];
    logic       exp_busy;
    txlog.delete();
    tx_ready = 1'b1;
    q0.push_back(8'h61); q0.push_back(8'h62); q0.push_back(8'h0A);
    tick();
    vectors++;
    if (grant !== 2'b00) begin
      miscompares++;
      $display("FAIL single_t0: grant=%b, expected 00", grant);
    end
    tick();
    vectors++;
    if (grant !== 2'b01 || req_ready !== 2'b01 || tx_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL single_t1: grant=%b req_ready=%b tx_valid=%b, expected 01 01 0", grant, req_ready, tx_valid);
    end
    exp.push_back(8'h61); exp.push_back(8'h62); exp.push_back(8'h0A);
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (tx_valid !== 1'b1 || tx_data !== exp[i]) begin
        miscompares++;
        $display("FAIL single_t%0d: tx_valid=%b tx_data=%h, expected 1 %h", i + 2, tx_valid, tx_data, exp[i]);
      end
    end
`ifdef UART_ARB_EOP_EN
    exp_busy = 1'b0;
`else
    exp_busy = 1'b1;
`endif
    vectors++;
    if (busy !== exp_busy) begin
      miscompares++;
      $display("FAIL single_busy_after_eop: busy=%b, expected %b", busy, exp_busy);
    end
    tick();
    vectors++;
    if (tx_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL single_drain: tx_valid=%b, expected 0", tx_valid);
    end
    wait_idle("single");
    vectors++;
    if (txlog.size() != 3) begin
      miscompares++;
      $display("FAIL single_len: got %0d bytes, expected 3", txlog.size());
    end
  endtask

  task automatic test_burst();
    logic [7:0] exp[$];
    txlog.delete();
    tx_ready = 1'b1;
    for (int i = 0; i < 20; i++) q0.push_back(8'h41);
    tick();
    for (int i = 0; i < 3; i++) q1.push_back(8'h42);
    for (int i = 0; i < 16; i++) exp.push_back(8'h41);
    for (int i = 0; i < 3; i++)  exp.push_back(8'h42);
    for (int i = 0; i < 4; i++)  exp.push_back(8'h41);
    wait_idle("burst");
    vectors++;
    if (txlog.size() != exp.size()) begin
      miscompares++;
      $display("FAIL burst_len: got %0d bytes, expected %0d", txlog.size(), exp.size());
    end
    for (int i = 0; i < exp.size() && i < txlog.size(); i++) begin
      vectors++;
      if (txlog[i] !== exp[i]) begin
        miscompares++;
        $display("FAIL burst_byte%0d: got %h expected %h", i, txlog[i], exp[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    int n = 0;
    txlog.delete();
    tx_ready = 1'b1;
    for (int i = 0; i < 5; i++) q0.push_back(8'h30 + 8'(i));
    while (!(tx_valid === 1'b1 && tx_data === 8'h31) && n < 50) begin
      tick();
      n++;
    end
    vectors++;
    if (n >= 50) begin
      miscompares++;
      $display("FAIL bp_start: tx_valid=%b tx_data=%h, expected 1 31 within 50 cycles", tx_valid, tx_data);
    end
    tx_ready = 1'b0;
    #1;
    for (int i = 0; i < 50; i++) begin
      vectors++;
      if (tx_valid !== 1'b1 || tx_data !== 8'h31 || req_ready !== 2'b00 || grant !== 2'b01) begin
        miscompares++;
        $display("FAIL bp_hold%0d: tx_valid=%b tx_data=%h req_ready=%b grant=%b, expected 1 31 00 01",
                 i, tx_valid, tx_data, req_ready, grant);
      end
      tick();
    end
    tx_ready = 1'b1;
    wait_idle("bp");
    vectors++;
    if (txlog.size() != 5) begin
      miscompares++;
      $display("FAIL bp_len: got %0d bytes, expected 5", txlog.size());
    end
    for (int i = 0; i < 5 && i < txlog.size(); i++) begin
      vectors++;
      if (txlog[i] !== 8'h30 + 8'(i)) begin
        miscompares++;
        $display("FAIL bp_byte%0d: got %h expected %h", i, txlog[i], 8'h30 + 8'(i));
      end
    end
  endtask

  task automatic test_stall();
    txlog.delete();
    tx_ready = 1'b1;
    q0.push_back(8'h55);
    tick();
    tick();
    vectors++;
    if (grant !== 2'b01 || req_ready !== 2'b01) begin
      miscompares++;
      $display("FAIL stall_grant0: grant=%b req_ready=%b, expected 01 01", grant, req_ready);
    end
    q1.push_back(8'h66);
    tick();
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if (grant !== 2'b01 || req_ready[1] !== 1'b0) begin
        miscompares++;
        $display("FAIL stall_hold%0d: grant=%b req_ready=%b, expected 01 0x", i, grant, req_ready);
      end
      tick();
    end
    vectors++;
    if (grant !== 2'b00 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL stall_release: grant=%b busy=%b, expected 00 0", grant, busy);
    end
    tick();
    vectors++;
    if (grant !== 2'b10 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL stall_rotate: grant=%b busy=%b, expected 10 1", grant, busy);
    end
    wait_idle("stall");
    vectors++;
    if (txlog.size() != 2 || txlog[0] !== 8'h55 || txlog[1] !== 8'h66) begin
      miscompares++;
      $display("FAIL stall_log: got %0d bytes first=%h, expected 2 bytes 55 66",
               txlog.size(), (txlog.size() > 0) ? txlog[0] : 8'hxx);
    end
  endtask

  task automatic test_reset_midpacket();
    int n = 0;
    tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) q0.push_back(8'h70 + 8'(i));
    while (tx_valid !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    vectors++;
    if (n >= 50) begin
      miscompares++;
      $display("FAIL mid_start: tx_valid=%b, expected 1 within 50 cycles", tx_valid);
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if (grant !== 2'b00 || busy !== 1'b0 || tx_valid !== 1'b0 || req_ready !== 2'b00 || tx_data !== 8'h00) begin
      miscompares++;
      $display("FAIL mid_async_reset: grant=%b busy=%b tx_valid=%b req_ready=%b tx_data=%h, expected 00 0 0 00 00",
               grant, busy, tx_valid, req_ready, tx_data);
    end
    q0.delete();
    q1.delete();
    tick();
    q0.push_back(8'h74);
    q1.push_back(8'h75);
    tick();
    rst_n = 1'b1;
    txlog.delete();
    tick();
    vectors++;
    if (grant !== 2'b01) begin
      miscompares++;
      $display("FAIL mid_restart: grant=%b, expected 01", grant);
    end
    wait_idle("mid");
    vectors++;
    if (txlog.size() != 2 || txlog[0] !== 8'h74 || txlog[1] !== 8'h75) begin
      miscompares++;
      $display("FAIL mid_log: got %0d bytes first=%h, expected 2 bytes 74 75",
               txlog.size(), (txlog.size() > 0) ? txlog[0] : 8'hxx);
    end
  endtask

  initial begin
    test_reset();
    test_contention();
    test_single();
    test_burst();
    test_backpressure();
    test_stall();
    test_reset_midpacket();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that shares one `uart_transmitter` byte channel between `NUM_REQ` independent byte sources (e.g. button-character source, ROM reader). It grants the channel to one requester at a time and holds the grant for a packet: until an end-of-packet byte, a burst limit, or a stall timeout, whichever comes first. It sits between the sources and the transmitter's `data_in`/`data_in_valid`/`data_in_ready` port, with one output register.

## Interface
- `NUM_REQ`, 2: number of requesters (2..8).
- `BURST_MAX`, 16: max bytes per grant before forced rotation (≥1).
- `HOLD_CYCLES`, 1024: consecutive cycles of granted `req_valid` low before release (≥1).
- `EOP_BYTE`, 8'h0A: byte that ends a packet (when `UART_ARB_EOP_EN` is defined).

- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_data`  in  8*NUM_REQ  byte from requester i at bits [8i+7:8i].
- `req_valid`  in  NUM_REQ  requester i has a byte.
- `req_ready`  out  NUM_REQ  byte of requester i accepted this cycle when valid&ready.
- `tx_data`  out  8  byte to transmitter `data_in`.
- `tx_valid`  out  1  to transmitter `data_in_valid`.
- `tx_ready`  in  1  from transmitter `data_in_ready`.
- `grant`  out  NUM_REQ  one-hot current owner; 0 when idle.
- `busy`  out  1  high in GRANT state.

## Operation
- States: IDLE, GRANT.
- IDLE: if any `req_valid`, pick first valid index searching from `last+1` modulo NUM_REQ; register `grant`, set `last` to it, clear `byte_cnt` and `hold_cnt`, go to GRANT. Else stay.
- GRANT: `req_ready[g] = ~tx_valid | tx_ready`; all other `req_ready` bits 0. Accepted byte loads `tx_data`, sets `tx_valid`, increments `byte_cnt`, clears `hold_cnt`.
- GRANT, `req_valid[g]` low: `hold_cnt` increments.
- Release to IDLE (`grant`←0) on: accepted byte is the `BURST_MAX`-th; accepted byte equals `EOP_BYTE` (macro on); `hold_cnt` reaching `HOLD_CYCLES`.
- Output register: `tx_valid` clears when `tx_ready` and no new byte accepted; it drains independently of state. Byte accepted and `tx_ready` in the same cycle: register replaced, `tx_valid` stays 1.
- `tx_data`/`tx_valid` never change while `tx_valid & ~tx_ready`.
- Non-granted requesters wait; no byte is dropped or duplicated.
- Widths: `byte_cnt` `$clog2(BURST_MAX+1)`, `hold_cnt` `$clog2(HOLD_CYCLES+1)`, saturating not needed (release precedes wrap).

## Timing
- Reset (async, while `rst_n`=0): state IDLE, `grant`=0, `busy`=0, `req_ready`=0, `tx_valid`=0, `tx_data`=0, `last`=NUM_REQ-1 (requester 0 wins first).
- Request seen in IDLE at cycle t: `grant`/`busy` high t+1; first `req_ready` t+1 (if output register empty or draining); `tx_valid` t+2.
- Final byte accepted at t: IDLE at t+1, next grant at t+2. One dead cycle per rotation.
- Throughput within a grant: one byte per cycle when `tx_ready` held high.
- `req_ready` is combinational from `tx_ready`; `tx_valid`/`tx_data` are registered.
- Reset deasserted mid-packet: in-flight byte in output register lost; arbitration restarts at requester 0.

## Configuration
- `UART_ARB_EOP_EN` defined: `EOP_BYTE` acceptance releases the grant (EOP byte itself is transmitted).
- Not defined: `EOP_BYTE` is ordinary data; release only on `BURST_MAX` or `HOLD_CYCLES`.

## Test plan
- Reset: hold `rst_n`=0 with all `req_valid`=1 -> `grant`=0, `tx_valid`=0, `req_ready`=0; release -> `grant`=2'b01 one cycle later.
- Single source, `tx_ready`=1: req0 sends "ab\n" (61,62,0A) -> `tx_data` 61,62,0A on consecutive cycles from t+2; macro on -> `busy` low cycle after 0A.
- Contention: both sources hold valid, streams "A\n"/"b\n" repeated -> transmitted order alternates req0, req1, req0 packets; no interleaving inside a packet.
- Burst limit, macro off: req0 sends 20 bytes of 41, req1 valid -> 16 bytes from req0, then req1, then remaining 4 from req0.
- Backpressure: `tx_ready` low 50 cycles mid-packet -> `tx_data`/`tx_valid` stable, `req_ready[g]`=0, no loss; resume -> sequence intact.
- Stall timeout: req0 sends 1 byte then drops valid, `HOLD_CYCLES`=8, req1 valid -> grant moves to req1 exactly 8 cycles after req0 drop, plus one IDLE cycle.
